// File: rtl/fifo_word_packer_if.sv
// fifo_word_packer_if: FIFO-side and consumer-side signals of the word packer.
interface fifo_word_packer_if #(
   parameter int FIFO_WIDTH = 8,
   parameter int PACK       = 4
);
   logic                       wr_en;
   logic [FIFO_WIDTH-1:0]      fifo_data;
   logic                       read;
   logic                       flush;
   logic [FIFO_WIDTH*PACK-1:0] word_o;
   logic [3:0]                 word_bytes;
   logic                       word_valid;
   logic                       word_ready;
   logic [3:0]                 level;
   logic                       overflow;
   modport master (
      input  wr_en, fifo_data, flush, word_ready,
      output read, word_o, word_bytes, word_valid, level, overflow
   );
   modport slave (
      output wr_en, fifo_data, flush, word_ready,
      input  read, word_o, word_bytes, word_valid, level, overflow
   );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains a sync FIFO, packs PACK entries per word onto a valid/ready port.
module fifo_word_packer #(
   parameter int FIFO_WIDTH = 8,
   parameter int PACK       = 4,
   parameter int DEPTH      = 15
) (
   input logic                clk,
   input logic                rst,
   fifo_word_packer_if.master bus
);
   localparam int IW = $clog2(PACK + 1);
   typedef enum logic {FILL, OUT} state_t;
   state_t        state;
   logic [IW-1:0] idx;
   logic          rd_pend;
   logic          flush_arm;
   // A pop in a push cycle would make the FIFO drop the push, so wr_en blocks reads.
   assign bus.read = state == FILL && bus.level != 4'd0 && !bus.wr_en &&
                     (32'(idx) + 32'(rd_pend)) < PACK && !flush_arm;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= FILL;
         idx            <= '0;
         rd_pend        <= 1'b0;
         flush_arm      <= 1'b0;
         bus.level      <= '0;
         bus.overflow   <= 1'b0;
         bus.word_o     <= '0;
         bus.word_bytes <= '0;
         bus.word_valid <= 1'b0;
      end else begin
         rd_pend <= bus.read;
         if (bus.read)
            bus.level <= bus.level - 4'd1;
         else if (bus.wr_en && bus.level < 4'(DEPTH))
            bus.level <= bus.level + 4'd1;
         else if (bus.wr_en)
            bus.overflow <= 1'b1;
         if (state == FILL) begin
            if (rd_pend) begin
               bus.word_o[32'(idx)*FIFO_WIDTH +: FIFO_WIDTH] <= bus.fifo_data;
               idx <= idx + 1'b1;
               if (32'(idx) + 1 == PACK) begin
                  state          <= OUT;
                  bus.word_valid <= 1'b1;
                  bus.word_bytes <= 4'(PACK);
               end
            end else if (flush_arm) begin
               if (idx != '0) begin
                  state          <= OUT;
                  bus.word_valid <= 1'b1;
                  bus.word_bytes <= 4'(idx);
               end else
                  flush_arm <= 1'b0;
            end
            // A flush arriving as an empty flush retires stays armed.
            if (bus.flush)
               flush_arm <= 1'b1;
         end else if (bus.word_ready) begin
            state          <= FILL;
            idx            <= '0;
            flush_arm      <= 1'b0;
            bus.word_o     <= '0;
            bus.word_valid <= 1'b0;
         end
      end
   end
endmodule
